// File: rtl/ch3_wt_join_pkg.sv
// Shared types and constants for the two-digit time-entry assembler.
package ch3_wt_join_pkg;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_ONES = 1'b1
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_DIGIT   = 2'b01;
   localparam logic [1:0] ERR_RANGE   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/ch3_wt_timeout.sv
// Inter-digit timeout counter: clear wins over enable, expire flags TIMEOUT_CYCLES-1.
// Expire is combinational from the count; no backpressure.
module ch3_wt_timeout #(
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int CNT_W          = 23
)(
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ch3_wt_join.sv
// Assembles a tens strobe and a ones strobe into a validated binary value.
// One-cycle latency from accepting strobe to NUMBER_VALID/ERROR pulse; no backpressure.
module ch3_wt_join #(
   parameter int MAX_VALUE      = 59,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int CNT_W          = 23
)(
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_digit_valid,
   input  logic [3:0] i_digit,
   input  logic       i_cancel,
   output logic [6:0] o_number,
   output logic       o_number_valid,
   output logic       o_error,
   output logic [1:0] o_err_code,
   output logic       o_busy,
   output logic [3:0] o_tens_pending
);
   import ch3_wt_join_pkg::*;

   localparam logic [6:0] MAX_V    = 7'(MAX_VALUE);
   localparam logic [3:0] MAX_TENS = 4'(MAX_VALUE / 10);

   state_t     r_state;
   logic [3:0] r_tens;
   logic [6:0] r_number;
   logic       r_number_valid;
   logic       r_error;
   logic [1:0] r_err_code;
   logic       r_busy;

   logic       w_bad_digit;
   logic [6:0] w_tens_x10;
   logic [6:0] w_sum;
   logic       w_cnt_clr;
   logic       w_cnt_en;
   logic       w_expire;

   assign w_bad_digit = (i_digit > BCD_MAX);
   assign w_tens_x10  = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0};
   assign w_sum       = w_tens_x10 + {3'b000, i_digit};

   // Counter only runs while waiting for the ones digit with nothing else happening.
   assign w_cnt_clr = (r_state != WAIT_ONES) | i_cancel | i_digit_valid;
   assign w_cnt_en  = ~w_cnt_clr;

   ch3_wt_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state        <= IDLE;
         r_tens         <= 4'd0;
         r_number       <= 7'd0;
         r_number_valid <= 1'b0;
         r_error        <= 1'b0;
         r_err_code     <= ERR_NONE;
         r_busy         <= 1'b0;
      end else begin
         r_number_valid <= 1'b0;
         r_error        <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_digit_valid && !i_cancel) begin
                  if (w_bad_digit) begin
                     r_error    <= 1'b1;
                     r_err_code <= ERR_DIGIT;
                  end else if (i_digit > MAX_TENS) begin
                     r_error    <= 1'b1;
                     r_err_code <= ERR_RANGE;
                  end else begin
                     r_tens  <= i_digit;
                     r_busy  <= 1'b1;
                     r_state <= WAIT_ONES;
                  end
               end
            end
            WAIT_ONES: begin
               if (i_cancel || i_digit_valid || w_expire) begin
                  r_tens  <= 4'd0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               if (!i_cancel) begin
                  if (i_digit_valid) begin
                     if (w_bad_digit) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_DIGIT;
                     end else if (w_sum > MAX_V) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_RANGE;
                     end else begin
                        r_number       <= w_sum;
                        r_number_valid <= 1'b1;
                     end
                  end else if (w_expire) begin
                     r_error    <= 1'b1;
                     r_err_code <= ERR_TIMEOUT;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_number       = r_number;
   assign o_number_valid = r_number_valid;
   assign o_error        = r_error;
   assign o_err_code     = r_err_code;
   assign o_busy         = r_busy;
   assign o_tens_pending = r_tens;

endmodule

// File: tb/tb_ch3_wt_join.sv
// Bench for ch3_wt_join: vector table plus timeout/reset/parameter sequences, pulses scoreboarded.
module tb_ch3_wt_join;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       dv = 1'b0;
   logic [3:0] dig = 4'd0;
   logic       cxl = 1'b0;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   logic [6:0] a_num, b_num, c_num;
   logic       a_nv, b_nv, c_nv;
   logic       a_er, b_er, c_er;
   logic [1:0] a_ec, b_ec, c_ec;
   logic       a_bsy, b_bsy, c_bsy;
   logic [3:0] a_tp, b_tp, c_tp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ch3_wt_join #(.MAX_VALUE(59), .TIMEOUT_CYCLES(8), .CNT_W(4)) u59 (
      .i_clk(clk), .i_resetn(rstn), .i_digit_valid(dv), .i_digit(dig), .i_cancel(cxl),
      .o_number(a_num), .o_number_valid(a_nv), .o_error(a_er), .o_err_code(a_ec),
      .o_busy(a_bsy), .o_tens_pending(a_tp));

   ch3_wt_join #(.MAX_VALUE(23), .TIMEOUT_CYCLES(8), .CNT_W(4)) u23 (
      .i_clk(clk), .i_resetn(rstn), .i_digit_valid(dv), .i_digit(dig), .i_cancel(cxl),
      .o_number(b_num), .o_number_valid(b_nv), .o_error(b_er), .o_err_code(b_ec),
      .o_busy(b_bsy), .o_tens_pending(b_tp));

   ch3_wt_join #(.MAX_VALUE(99), .TIMEOUT_CYCLES(8), .CNT_W(4)) u99 (
      .i_clk(clk), .i_resetn(rstn), .i_digit_valid(dv), .i_digit(dig), .i_cancel(cxl),
      .o_number(c_num), .o_number_valid(c_nv), .o_error(c_er), .o_err_code(c_ec),
      .o_busy(c_bsy), .o_tens_pending(c_tp));

   // pulse kinds: 0 none, 1 NUMBER_VALID, 2 ERROR
   typedef struct {
      logic       dv;
      logic [3:0] dig;
      logic       cxl;
      logic       busy;
      logic [3:0] tens;
      logic [6:0] num;
      logic [1:0] err;
      int         pulse;
   } vec_t;

   typedef struct {
      int         kind;
      logic [6:0] num;
      logic [1:0] err;
      int         due;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   vec_t vt[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; an expected pulse is queued as the strobe is driven.
   task automatic step(input logic d_v, input logic [3:0] d, input logic c,
                       input int pulse, input logic [6:0] num, input logic [1:0] err);
      @(negedge clk);
      dv  = d_v;
      dig = d;
      cxl = c;
      if (pulse != 0) sbq.push_back('{pulse, num, err, cyc + 1});
      @(posedge clk);
      #1;
   endtask

   task automatic chk59(input string tag, input logic busy, input logic [3:0] tens,
                        input logic [6:0] num, input logic [1:0] err);
      chk({tag, "_busy"}, 32'(a_bsy), 32'(busy));
      chk({tag, "_tens"}, 32'(a_tp), 32'(tens));
      chk({tag, "_num"}, 32'(a_num), 32'(num));
      chk({tag, "_err"}, 32'(a_ec), 32'(err));
   endtask

   // Scoreboard for the MAX_VALUE=59 instance.
   always @(negedge clk) begin
      if (a_nv || a_er) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_pulse", {30'd0, a_nv, a_er}, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("sb_kind", {30'd0, a_nv, a_er}, (mon_e.kind == 1) ? 32'd2 : 32'd1);
            chk("sb_cycle", 32'(cyc), 32'(mon_e.due));
            chk("sb_num", 32'(a_num), 32'(mon_e.num));
            chk("sb_err", 32'(a_ec), 32'(mon_e.err));
         end
      end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
         mon_e = sbq.pop_front();
         chk("sb_missing_pulse", {30'd0, a_nv, a_er}, (mon_e.kind == 1) ? 32'd2 : 32'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //        dv   dig    cxl  busy tens   num    err  pulse
      vt[0]  = '{1'b1, 4'd4, 1'b0, 1'b1, 4'd4, 7'd0,  2'd0, 0};
      vt[1]  = '{1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 7'd47, 2'd0, 1};
      vt[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 7'd47, 2'd0, 0};
      vt[3]  = '{1'b1, 4'd6, 1'b0, 1'b0, 4'd0, 7'd47, 2'd2, 2};
      vt[4]  = '{1'b1, 4'hC, 1'b0, 1'b0, 4'd0, 7'd47, 2'd1, 2};
      vt[5]  = '{1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 7'd47, 2'd1, 0};
      vt[6]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'd0, 7'd47, 2'd1, 2};
      vt[7]  = '{1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 7'd47, 2'd1, 0};
      vt[8]  = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 7'd47, 2'd1, 0};
      vt[9]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 7'd47, 2'd1, 0};
      vt[10] = '{1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 7'd9,  2'd1, 1};
      vt[11] = '{1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 7'd9,  2'd1, 0};
      vt[12] = '{1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 7'd59, 2'd1, 1};
      vt[13] = '{1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 7'd59, 2'd1, 0};
      vt[14] = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 7'd59, 2'd1, 0};
      vt[15] = '{1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 7'd0,  2'd1, 1};

      repeat (2) @(posedge clk);
      #1;
      chk59("reset", 1'b0, 4'd0, 7'd0, 2'd0);
      chk("reset_pulses", {30'd0, a_nv, a_er}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(vt[i].dv, vt[i].dig, vt[i].cxl, vt[i].pulse, vt[i].num, vt[i].err);
         chk59($sformatf("row%0d", i), vt[i].busy, vt[i].tens, vt[i].num, vt[i].err);
      end

      // Timeout: tens 2, then silence; error lands on the 8th idle cycle.
      step(1'b0, 4'd0, 1'b1, 0, 7'd0, 2'd0);
      step(1'b1, 4'd2, 1'b0, 0, 7'd0, 2'd0);
      for (int k = 0; k < 7; k++) begin
         step(1'b0, 4'd0, 1'b0, 0, 7'd0, 2'd0);
         chk($sformatf("to_wait%0d_busy", k), 32'(a_bsy), 32'd1);
      end
      step(1'b0, 4'd0, 1'b0, 2, 7'd0, 2'd3);
      chk59("timeout", 1'b0, 4'd0, 7'd0, 2'd3);

      // Ones digit on the expiry cycle wins over the timeout.
      step(1'b1, 4'd2, 1'b0, 0, 7'd0, 2'd0);
      for (int k = 0; k < 7; k++) step(1'b0, 4'd0, 1'b0, 0, 7'd0, 2'd0);
      step(1'b1, 4'd5, 1'b0, 1, 7'd25, 2'd3);
      chk59("expiry_digit", 1'b0, 4'd0, 7'd25, 2'd3);
      step(1'b0, 4'd0, 1'b0, 0, 7'd0, 2'd0);

      // Asynchronous reset in the middle of a clock period discards the pending tens.
      step(1'b0, 4'd0, 1'b1, 0, 7'd0, 2'd0);
      step(1'b1, 4'd5, 1'b0, 0, 7'd0, 2'd0);
      chk59("pre_reset", 1'b1, 4'd5, 7'd25, 2'd3);
      #2;
      rstn = 1'b0;
      #1;
      chk59("async_reset", 1'b0, 4'd0, 7'd0, 2'd0);
      chk("async_reset_u99_busy", 32'(c_bsy), 32'd0);
      step(1'b0, 4'd0, 1'b0, 0, 7'd0, 2'd0);
      @(negedge clk);
      rstn = 1'b1;

      // 9,9: only the MAX_VALUE=99 instance accepts it.
      step(1'b1, 4'd9, 1'b0, 2, 7'd0, 2'd2);
      step(1'b1, 4'd9, 1'b0, 2, 7'd0, 2'd2);
      chk("u99_num", 32'(c_num), 32'd99);
      chk("u99_valid", 32'(c_nv), 32'd1);
      chk("u23_err_after_9", 32'(b_ec), 32'd2);
      step(1'b0, 4'd0, 1'b0, 0, 7'd0, 2'd0);
      chk("u99_valid_width", 32'(c_nv), 32'd0);

      // 2,4 exceeds 23 but is fine for 59 and 99.
      step(1'b1, 4'd2, 1'b0, 0, 7'd0, 2'd0);
      chk("u23_busy", 32'(b_bsy), 32'd1);
      step(1'b1, 4'd4, 1'b0, 1, 7'd24, 2'd2);
      chk("u23_error", 32'(b_er), 32'd1);
      chk("u23_errcode", 32'(b_ec), 32'd2);
      chk("u23_num_held", 32'(b_num), 32'd0);
      chk("u23_idle", 32'(b_bsy), 32'd0);
      chk("u99_num24", 32'(c_num), 32'd24);
      step(1'b1, 4'd2, 1'b0, 0, 7'd0, 2'd0);
      step(1'b1, 4'd3, 1'b0, 1, 7'd23, 2'd2);
      chk("u23_num23", 32'(b_num), 32'd23);
      chk("u23_valid23", 32'(b_nv), 32'd1);

      repeat (3) step(1'b0, 4'd0, 1'b0, 0, 7'd0, 2'd0);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ch3_wt_join.md
Name: ch3_wt_join

Overview:
- Serial two-digit entry assembler for the alarm clock's time-set path. It is the inverse of the number-to-digit splitter.
- Accepts a tens digit, then a ones digit, each as a one-cycle strobe from the button/keypad front end.
- Validates both digits and emits the binary value 0..MAX_VALUE on NUMBER with a one-cycle NUMBER_VALID pulse.
- Feeds the hour/minute/second set registers.

Parameters:
- MAX_VALUE, 59, largest accepted combined value (legal range 9..99); 59 for min/sec, 23 for hours.
- TIMEOUT_CYCLES, 5000000, cycles allowed between tens and ones digit before abort (≥2).
- CNT_W, 23, width of timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- CLK  input  1  system clock, rising edge
- RESETN  input  1  asynchronous active-low reset
- DIGIT_VALID  input  1  one-cycle strobe: DIGIT is presented
- DIGIT  input  4  BCD digit, sampled only when DIGIT_VALID=1
- CANCEL  input  1  abort current entry
- NUMBER  output  7  last successfully assembled binary value (held)
- NUMBER_VALID  output  1  one-cycle pulse: NUMBER updated
- ERROR  output  1  one-cycle pulse: entry rejected/aborted
- ERR_CODE  output  2  reason for last ERROR (held): 00 none, 01 bad digit, 10 out of range, 11 timeout
- BUSY  output  1  high while waiting for ones digit
- TENS_PENDING  output  4  accepted tens digit, for display; 0 when idle

Behaviour:
- Reset (RESETN=0, async): state IDLE, NUMBER=0, NUMBER_VALID=0, ERROR=0, ERR_CODE=00, BUSY=0, TENS_PENDING=0, timeout counter=0. All outputs registered.
- States: IDLE, WAIT_ONES.
- IDLE, DIGIT_VALID=1:
  - DIGIT>9: ERROR pulse next cycle, ERR_CODE=01, stay IDLE.
  - DIGIT > MAX_VALUE/10 (integer divide; 5 for 59): ERROR pulse, ERR_CODE=10, stay IDLE.
  - Otherwise latch tens, TENS_PENDING=DIGIT, counter=0, go WAIT_ONES; BUSY=1 from next cycle.
- WAIT_ONES, DIGIT_VALID=1:
  - DIGIT>9: ERROR, ERR_CODE=01.
  - tens*10+DIGIT > MAX_VALUE: ERROR, ERR_CODE=10.
  - Otherwise NUMBER=tens*10+DIGIT and NUMBER_VALID=1 on the next edge; ERR_CODE unchanged.
  - All cases return to IDLE with BUSY=0 and TENS_PENDING=0.
- WAIT_ONES, no digit: counter increments each cycle. When counter reaches TIMEOUT_CYCLES-1, next edge gives ERROR, ERR_CODE=11, IDLE.
- Latency: one cycle from accepting strobe to NUMBER_VALID/ERROR pulse. Pulses are exactly one cycle wide.
- Arithmetic: tens*10 computed as (tens<<3)+(tens<<1) in 7 bits. Max 9*10+9=99 fits, no overflow.
- Priority, highest first: RESETN, CANCEL, DIGIT_VALID, timeout.
  - CANCEL in WAIT_ONES: IDLE, no ERROR, no NUMBER change, digit that cycle dropped.
  - CANCEL in IDLE: no effect, and any simultaneous digit is dropped.
  - Digit arriving in the same cycle the timeout would expire is accepted normally; no timeout error.
- NUMBER and ERR_CODE hold until overwritten; an error never alters NUMBER.
- Back-to-back strobes on consecutive cycles are legal; no idle cycle required between entries.
- Reset mid-entry discards the pending tens digit; no pulse is generated.

Decomposition:
- Shared package: state encoding (IDLE, WAIT_ONES), ERR_CODE constants (ERR_NONE, ERR_DIGIT, ERR_RANGE, ERR_TIMEOUT), and BCD_MAX=9.
- One natural sub-module: ch3_wt_timeout, a loadable CNT_W counter with clear/enable and an expire flag.
- Digit check and multiply-by-10 stay inline.

Test Plan:
- Reset then strobes 4, 7 (MAX_VALUE=59) → one cycle after second strobe NUMBER=47, NUMBER_VALID=1 for exactly one cycle; BUSY=1 between strobes; TENS_PENDING=4 then 0.
- Strobe 6 in IDLE (MAX_VALUE=59) → ERROR pulse, ERR_CODE=10, BUSY stays 0. Same test with MAX_VALUE=23: strobes 2, 4 → ERROR, ERR_CODE=10, NUMBER unchanged.
- Strobe 12 (0xC) as tens → ERR_CODE=01. Strobe 3 then 0xA → ERR_CODE=01, NUMBER unchanged, back to IDLE.
- TIMEOUT_CYCLES=8: strobe 2, then no digit → ERROR with ERR_CODE=11 after 8 cycles. Repeat with ones digit 5 on the expiry cycle → NUMBER=25, no ERROR.
- Strobe 3, then CANCEL together with DIGIT_VALID (digit 1) → IDLE, no pulses, NUMBER unchanged. Then strobes 0, 9 → NUMBER=9.
- Strobe 5, assert RESETN=0 asynchronously mid-cycle → all outputs reset immediately. After release, strobe 9 then 9 with MAX_VALUE=99 → NUMBER=99.
